dev_uart_tx: RTL and testbench



---
 rtl/dev_uart_tx_pkg.sv | 24 ++
 rtl/dev_uart_tx_sync_fifo.sv | 58 +++++
 rtl/dev_uart_tx.sv | 193 +++++++++++++++++++
 tb/tb_dev_uart_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dev_uart_tx_pkg.sv
// dev_uart_tx shared definitions: register map, status bits, FSM codes.
// Imported by the transmitter top and its FIFO.
package dev_uart_tx_pkg;

  localparam int REG_TXDATA  = 0;
  localparam int REG_STATUS  = 1;
  localparam int REG_DIVISOR = 2;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // A divisor of zero would stall the bit counter, so it runs at 1.
  function automatic logic [7:0] eff_period(input logic [7:0] div);
    return (div == 8'd0) ? 8'd1 : div;
  endfunction

endpackage

// File: rtl/dev_uart_tx_sync_fifo.sv
// Synchronous FIFO with exact count and first-word fall-through read.
// Push on full is dropped unless a pop frees the slot in the same cycle.
module dev_uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/dev_uart_tx.sv
// Bus-mapped 8N1 UART transmitter: TX FIFO, status/divisor regs,
// strobe edge detection and the serial shift engine.
module dev_uart_tx
  import dev_uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int DIVISOR_RESET = 16,
  parameter int ADDR_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  _cs,
  input  logic                  _oe,
  input  logic                  _w,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  output logic                  txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_WIDTH-1:0] A_TX  = ADDR_WIDTH'(REG_TXDATA);
  localparam logic [ADDR_WIDTH-1:0] A_ST  = ADDR_WIDTH'(REG_STATUS);
  localparam logic [ADDR_WIDTH-1:0] A_DIV = ADDR_WIDTH'(REG_DIVISOR);

  logic          w_prev_q, w_prev_d;
  logic          r_prev_q, r_prev_d;
  logic          cs_w, cs_oe, wr_evt, rd_evt;
  logic          sel_tx, sel_st, sel_div;

  logic [7:0]    div_q, div_d;
  logic          ovf_q, ovf_d;

  logic [1:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    per_q, per_d;
  logic          txd_q, txd_d;
  logic          last, load;

  logic          fifo_push, fifo_pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [3:0]    cnt4;
  logic [7:0]    status, rd_data;

  assign cs_w   = _cs | _w;
  assign cs_oe  = _cs | _oe;
  assign wr_evt = ~cs_w & w_prev_q;
  assign rd_evt = ~cs_oe & r_prev_q & _w;
  assign w_prev_d = cs_w;
  assign r_prev_d = cs_oe;

  assign sel_tx  = (addr == A_TX);
  assign sel_st  = (addr == A_ST);
  assign sel_div = (addr == A_DIV);

  assign fifo_push = wr_evt & sel_tx;

  dev_uart_tx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (_reset),
    .push  (fifo_push),
    .wdata (data_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cnt4 = 4'(fifo_count);

  always_comb begin
    status           = '0;
    status[7:4]      = cnt4;
    status[ST_BUSY]  = (state_q != S_IDLE);
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_OVF]   = ovf_q;
  end

  assign data_oe = ~_cs & ~_oe & _w;

  always_comb begin
    rd_data = 8'h00;
    unique case (1'b1)
      sel_st:  rd_data = status;
      sel_div: rd_data = div_q;
      default: rd_data = 8'h00;
    endcase
  end

  assign data_out = data_oe ? rd_data : 8'h00;

  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_evt & sel_div) div_d = data_in;
    if (fifo_push & fifo_full & ~fifo_pop) ovf_d = 1'b1;
    if (rd_evt & sel_st) ovf_d = 1'b0;
  end

  // A frame load happens from IDLE, or straight out of STOP with no gap.
  assign last = (cnt_q == 8'd0);
  assign load = ~fifo_empty &
                ((state_q == S_IDLE) | ((state_q == S_STOP) & last));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    per_d    = per_q;
    txd_d    = txd_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      S_IDLE: txd_d = 1'b1;
      S_START: begin
        cnt_d = cnt_q - 8'd1;
        if (last) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          txd_d   = sh_q[0];
          cnt_d   = per_q - 8'd1;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q - 8'd1;
        if (last) begin
          cnt_d = per_q - 8'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            txd_d = sh_q[1];
          end
        end
      end
      S_STOP: begin
        cnt_d = cnt_q - 8'd1;
        if (last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      fifo_pop = 1'b1;
      state_d  = S_START;
      sh_d     = fifo_rdata;
      per_d    = eff_period(div_q);
      cnt_d    = eff_period(div_q) - 8'd1;
      txd_d    = 1'b0;
    end
  end

  assign txd = txd_q;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      w_prev_q <= 1'b1;
      r_prev_q <= 1'b1;
      div_q    <= 8'(DIVISOR_RESET);
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 3'd0;
      sh_q     <= 8'd0;
      per_q    <= 8'd1;
      txd_q    <= 1'b1;
    end else begin
      w_prev_q <= w_prev_d;
      r_prev_q <= r_prev_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      per_q    <= per_d;
      txd_q    <= txd_d;
    end
  end

endmodule

// File: tb/tb_dev_uart_tx.sv
// Self-checking bench for dev_uart_tx: random bytes/divisors against a
// frame-level serial model and a count-based status model.
module tb_dev_uart_tx;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       _reset = 1'b0;
  logic       _cs = 1'b1;
  logic       _oe = 1'b1;
  logic       _w = 1'b1;
  logic [3:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       data_oe;
  logic       txd;

  dev_uart_tx #(
    .FIFO_DEPTH    (DEPTH),
    .DIVISOR_RESET (16),
    .ADDR_WIDTH    (4)
  ) dut (
    .clk      (clk),
    ._reset   (_reset),
    ._cs      (_cs),
    ._oe      (_oe),
    ._w       (_w),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         p;
    bit         b2b;
    int         start_at;
  } frame_t;

  frame_t exp_q[$];
  int     n_chk = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     accepted = 0;
  int     started = 0;
  bit     ovf_m = 1'b0;
  int     cur_p = 16;
  int     last_start = 0;
  bit     mon_busy = 1'b0;
  int     mon_t = 0;
  int     mon_p = 1;
  logic [9:0] mon_bits = '1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level receiver: each frame is start(0), 8 data LSB-first, stop(1),
  // every bit exactly p clocks; compared against the queued expectations.
  initial begin
    frame_t it;
    forever begin
      @(negedge clk);
      if (!_reset) begin
        mon_busy = 1'b0;
      end else if (!mon_busy) begin
        if (txd === 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("spurious_start", 1, 0);
          end else begin
            it = exp_q.pop_front();
            mon_busy = 1'b1;
            mon_t = 0;
            mon_p = it.p;
            mon_bits = {1'b1, it.data, 1'b0};
            if (it.start_at != 0) chk("start_latency", cyc, it.start_at);
            if (it.b2b) chk("b2b_gap", cyc - last_start, 10 * mon_p);
            last_start = cyc;
            started++;
          end
        end
      end else begin
        mon_t++;
        chk("txd_bit", txd, mon_bits[mon_t / mon_p]);
        if (mon_t == 10 * mon_p - 1) mon_busy = 1'b0;
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d,
                           input int hold, input bit b2b, input bit lat);
    frame_t it;
    @(negedge clk);
    if (a == 4'd0) begin
      if (accepted - started < DEPTH) begin
        it.data = d;
        it.p = cur_p;
        it.b2b = b2b;
        it.start_at = lat ? cyc + 2 : 0;
        exp_q.push_back(it);
        accepted++;
      end else begin
        ovf_m = 1'b1;
      end
    end
    if (a == 4'd2) cur_p = (d == 8'd0) ? 1 : int'(d);
    addr = a;
    data_in = d;
    _cs = 1'b0;
    _w = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    _cs = 1'b1;
    _w = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a;
    _cs = 1'b0;
    _oe = 1'b0;
    #1;
    d = data_out;
    chk("data_oe_rd", data_oe, 1);
    @(posedge clk);
    @(negedge clk);
    _cs = 1'b1;
    _oe = 1'b1;
  endtask

  task automatic chk_status(input string tag, input bit busy);
    logic [7:0] v, e;
    int c;
    c = accepted - started;
    e = {4'(c), ovf_m, c == 0, c == DEPTH, busy};
    bus_read(4'd1, v);
    chk(tag, v, e);
    ovf_m = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", n < 5000, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_model();
    exp_q.delete();
    accepted = 0;
    started = 0;
    ovf_m = 1'b0;
    cur_p = 16;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] b;
    int n, dv, guard;

    // 1: reset state
    repeat (3) @(negedge clk);
    chk("txd_in_reset", txd, 1);
    _reset = 1'b1;
    @(negedge clk);
    chk("data_oe_idle", data_oe, 0);
    chk("data_out_idle", data_out, 8'h00);
    chk_status("status_reset", 1'b0);
    bus_read(4'd2, v);
    chk("divisor_reset", v, 8'h10);
    bus_read(4'd0, v);
    chk("txdata_reads_zero", v, 8'h00);
    chk("txd_idle", txd, 1);

    // 2: single frame at P=4
    bus_write(4'd2, 8'd4, 1, 0, 0);
    bus_read(4'd2, v);
    chk("divisor_rw", v, 8'd4);
    bus_write(4'd0, 8'hA5, 1, 0, 1);
    wait_drain();
    chk_status("status_after_a5", 1'b0);

    // 3: back-to-back at P=2
    bus_write(4'd2, 8'd2, 1, 0, 0);
    bus_write(4'd0, 8'h55, 1, 0, 1);
    bus_write(4'd0, 8'hAA, 1, 1, 0);
    wait_drain();

    // random bursts, divisor 0 included
    for (int r = 0; r < 8; r++) begin
      dv = $urandom_range(0, 6);
      bus_write(4'd2, 8'(dv), 1, 0, 0);
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        bus_write(4'd0, b, 1, k > 0, k == 0);
      end
      wait_drain();
      chk_status("status_burst_idle", 1'b0);
    end

    // 4: overflow at P=200, first byte has bit3 clear
    bus_write(4'd2, 8'd200, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      if (k == 0) b[3] = 1'b0;
      bus_write(4'd0, b, 1, k > 0, k == 0);
    end
    chk_status("status_overflow", 1'b1);
    chk_status("status_ovf_cleared", 1'b1);

    // 6: async reset in the middle of data bit 3
    guard = 0;
    while (cyc < last_start + 4 * 200 + 100 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_bit3", guard < 3000, 1);
    chk("txd_bit3_low", txd, 0);
    #2;
    _reset = 1'b0;
    #1;
    chk("txd_async_reset", txd, 1);
    reset_model();
    repeat (2) @(negedge clk);
    _reset = 1'b1;
    chk_status("status_post_reset", 1'b0);
    bus_read(4'd2, v);
    chk("divisor_post_reset", v, 8'h10);
    repeat (60) @(negedge clk);
    chk("txd_quiet", txd, 1);
    chk("no_frames_after_reset", started, 0);

    // 5: long-held write strobe pushes exactly one byte
    bus_write(4'd2, 8'd3, 1, 0, 0);
    bus_write(4'd0, 8'h3C, 1, 0, 1);
    bus_write(4'd0, 8'hC3, 5, 1, 0);
    chk_status("status_long_strobe", 1'b1);
    wait_drain();
    chk_status("status_final", 1'b0);
    chk("frames_total", started, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
